// File: rtl/alu_mul_ctrl_pkg.sv
// Shared mips_16 definitions used by the multiply sequencer: ALU command
// encodings and the 2-bit multiply-sequencer state encodings.
package alu_mul_ctrl_pkg;

   localparam logic [2:0] ALU_NC  = 3'd0;
   localparam logic [2:0] ALU_ADD = 3'd1;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/alu_mul_ctrl.sv
// Shift-add multiply sequencer that borrows the shared EX-stage ALU for its
// add steps, yielding to the pipeline whenever ex_req is high.
module alu_mul_ctrl
   import alu_mul_ctrl_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               ex_req,
   input  logic [WIDTH-1:0]   alu_r,
   input  logic               alu_cy,
   output logic               alu_own,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [2:0]         alu_cmd,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);

   mul_state_e           state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic                 step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MUL_IDLE;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      step    = 1'b0;
      alu_own = 1'b0;
      alu_a   = '0;
      alu_b   = '0;
      alu_cmd = ALU_NC;
      busy    = 1'b0;
      done    = 1'b0;

      case (state_q)
         MUL_IDLE: begin
            if (start) begin
               mcand_d = a;
               hi_d    = '0;
               lo_d    = b;
               cnt_d   = CNT_W'(WIDTH);
               state_d = MUL_RUN;
            end
         end

         MUL_RUN: begin
            busy = 1'b1;
            // A zero multiplier bit is a pure shift and never waits for the ALU.
            if (!lo_q[0]) begin
               hi_d = {1'b0, hi_q[WIDTH-1:1]};
               lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
               step = 1'b1;
            end else if (!ex_req) begin
               alu_own = 1'b1;
               alu_cmd = ALU_ADD;
               alu_a   = hi_q;
               alu_b   = mcand_q;
               hi_d    = {alu_cy, alu_r[WIDTH-1:1]};
               lo_d    = {alu_r[0], lo_q[WIDTH-1:1]};
               step    = 1'b1;
            end

            if (step) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_d == '0) begin
                  prod_d  = {hi_d, lo_d};
                  state_d = MUL_DONE;
               end
            end
         end

         MUL_DONE: begin
            done    = 1'b1;
            state_d = MUL_IDLE;
            if (start) begin
               mcand_d = a;
               hi_d    = '0;
               lo_d    = b;
               cnt_d   = CNT_W'(WIDTH);
               state_d = MUL_RUN;
            end
         end

         default: state_d = MUL_IDLE;
      endcase

      // Abort discards any step or new load and leaves the last product intact.
      if (abort) begin
         state_d = MUL_IDLE;
         mcand_d = mcand_q;
         hi_d    = hi_q;
         lo_d    = lo_q;
         cnt_d   = cnt_q;
         prod_d  = prod_q;
      end
   end

   assign prod = prod_q;

endmodule

// File: doc/alu_mul_ctrl.md
# alu_mul_ctrl

Multi-cycle unsigned 16x16→32 multiply sequencer for the mips_16 core. It has no multiplier of its own. It drives the shared 16-bit ALU with `ALU_ADD` steps (shift-add algorithm) and takes the ALU only on cycles the pipeline EX stage does not need it. It sits beside the EX stage and drives the select of the ALU operand/command mux.

## Interface
Parameters:
- `WIDTH`, 16: operand width. Product is 2*WIDTH.
- `CNT_W`, 5: step-counter width. Must hold the value WIDTH.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a multiply of `a`*`b`.
- `abort`  in  1: cancel the operation in flight.
- `a`  in  16: multiplicand.
- `b`  in  16: multiplier.
- `ex_req`  in  1: EX stage needs the ALU this cycle. EX always wins.
- `alu_r`  in  16: ALU result, valid in the same cycle as the operands.
- `alu_cy`  in  1: ALU carry, valid in the same cycle as the operands.
- `alu_own`  out  1: 1 = this block drives the ALU inputs this cycle.
- `alu_a`  out  16: ALU src1.
- `alu_b`  out  16: ALU src2.
- `alu_cmd`  out  3: ALU function select.
- `busy`  out  1: high in state RUN.
- `done`  out  1: one-cycle completion pulse.
- `prod`  out  32: product, held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers: `mcand`[15:0], `hi`[15:0], `lo`[15:0], `cnt`[CNT_W-1:0].
- Start acceptance:
  - `start` is accepted in IDLE or DONE: load `mcand`=a, `hi`=0, `lo`=b, `cnt`=16, then go to RUN.
  - `start` in RUN is ignored.
- RUN step, `lo[0]`=0: no ALU use. `{hi,lo} <= {1'b0,hi,lo} >> 1`, `cnt` decrements.
- RUN step, `lo[0]`=1 and `ex_req`=0:
  - Drive `alu_own`=1, `alu_cmd`=`ALU_ADD`, `alu_a`=hi, `alu_b`=mcand.
  - Update `{hi,lo} <= {alu_cy, alu_r, lo[15:1]}`, `cnt` decrements.
- RUN step, `lo[0]`=1 and `ex_req`=1: stall. `alu_own`=0, no register changes, `cnt` holds.
- End of run: when a step brings `cnt` to 0, go to DONE and load `prod` <= {hi,lo} result of that step.
- DONE: `done`=1 for exactly this cycle. Go to IDLE unless a new `start` is accepted.
- Whenever `alu_own`=0: `alu_a`=0, `alu_b`=0, `alu_cmd`=`ALU_NC`.
- `alu_own` is never high outside RUN.
- `abort` (sampled high in any state):
  - Next state is IDLE.
  - No `done` pulse; `prod` is unchanged.
  - `abort` has priority over `start` in the same cycle.
- Width rule: the carry from each add is shifted into `hi[15]`. The full 32-bit product is exact and never overflows.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `alu_own`=0, `alu_a`=0, `alu_b`=0, `alu_cmd`=`ALU_NC`, `prod`=0. Internal registers are 0.
- Nominal latency, `start` sampled at edge k:
  - RUN covers cycles k+1..k+16 (`busy`=1).
  - `done`=1 and `prod` is valid in cycle k+17.
- Each stalled cycle adds one cycle to the latency. A zero-bit step never stalls.
- Back-to-back: `start` sampled in the DONE cycle re-enters RUN on the next edge. `done` still pulses for the finished operation.
- Reset asserted mid-RUN: all outputs return to their reset values immediately (asynchronous). No `done` pulse occurs.
- `ex_req` is used combinationally for `alu_own` in the same cycle. The mux select must settle before the ALU samples.

## Structure
- `ALU_ADD` and `ALU_NC` are used from `mips_16_defs.v` and must not be redefined locally.
- Add `MUL_IDLE`, `MUL_RUN` and `MUL_DONE` state encodings (2 bits) to `mips_16_defs.v`.
- No sub-module. One state register, one counter and the shift datapath live in a single module.
- The ALU mux itself lives in the EX stage, selected by `alu_own`.

## Test plan
- a=3, b=5, `ex_req`=0, start at edge k -> `done` in cycle k+17, `prod`=0x0000000F. `alu_own` high in exactly 2 cycles.
- a=0xFFFF, b=0xFFFF -> `prod`=0xFFFE0001 at k+17. Carry path exercised every step.
- a=0xFFFF, b=0xFFFF, `ex_req` held high for cycles k+4..k+6 -> `alu_own`=0 in those cycles, `done` at k+20, `prod`=0xFFFE0001.
- a=0x1234, b=0 -> `alu_own` never asserts, `done` at k+17, `prod`=0.
- Abort and overlapping start:
  - Previous `prod`=0x0F. Start a=7, b=9, `abort` at k+5 -> IDLE at k+6, no `done`, `prod` stays 0x0F.
  - `start` pulsed during RUN is ignored.
- `rst` asserted at k+8 during a run -> all outputs at reset values before the next edge. A fresh start then yields a correct product.
